// File: rtl/frame_config_loader.sv
// rtl/frame_config_loader.sv - command/data stream to FrameData/one-hot FrameStrobe column loader
// Optional feature macro: CONFIG_CHECKSUM_EN (running XOR of written data words on cfg_checksum).
module frame_config_loader #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int SetupCycles     = 1,
  parameter int StrobeCycles    = 2
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic [31:0]                s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err,
  output logic [15:0]                frames_done,
  output logic [31:0]                cfg_checksum
);

  localparam int MaxCyc = (SetupCycles > StrobeCycles) ? SetupCycles : StrobeCycles;
  localparam int CW     = $clog2(MaxCyc + 1);
  localparam logic [CW-1:0] SetupLast  = CW'(SetupCycles - 1);
  localparam logic [CW-1:0] StrobeLast = CW'(StrobeCycles - 1);
  localparam logic [MaxFramesPerCol-1:0] StrobeOne = MaxFramesPerCol'(1);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, SETUP, STROBE, HOLD} state_t;

  state_t          state, next_state;
  logic [7:0]      frame_idx;
  logic            idx_bad;
  logic [CW-1:0]   cnt;
  logic            xfer, is_write, is_clear, cmd_bad, data_ok;

  assign xfer     = s_valid && s_ready;
  assign is_write = (s_data[31:30] == 2'b01);
  assign is_clear = (s_data[31:30] == 2'b10);
  assign cmd_bad  = ({24'd0, s_data[7:0]} >= 32'(MaxFramesPerCol));
  assign data_ok  = (state == WAIT_DATA) && xfer && !idx_bad;

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (xfer && is_write) next_state = WAIT_DATA;
      // a rejected index still consumes its data word so the stream stays aligned
      WAIT_DATA: if (xfer) next_state = idx_bad ? IDLE : SETUP;
      SETUP:     if (cnt == SetupLast) next_state = STROBE;
      STROBE:    if (cnt == StrobeLast) next_state = HOLD;
      HOLD:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // s_ready is gated by resetn so nothing is offered as accepted while reset is held
  always_comb begin
    s_ready     = 1'b0;
    busy        = 1'b1;
    FrameStrobe = '0;
    case (state)
      IDLE: begin
        s_ready = resetn;
        busy    = 1'b0;
      end
      WAIT_DATA: s_ready = resetn;
      STROBE:    FrameStrobe = StrobeOne << frame_idx;
      default:   ;
    endcase
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      frame_idx   <= '0;
      idx_bad     <= 1'b0;
      cnt         <= '0;
      FrameData   <= '0;
      err         <= 1'b0;
      frames_done <= '0;
    end else begin
      if ((state == SETUP || state == STROBE) && state == next_state) cnt <= cnt + 1'b1;
      else                                                            cnt <= '0;
      if (state == IDLE && xfer) begin
        if (is_write) begin
          frame_idx <= s_data[7:0];
          idx_bad   <= cmd_bad;
          if (cmd_bad) err <= 1'b1;
        end else if (is_clear) begin
          err         <= 1'b0;
          frames_done <= '0;
        end
      end
      if (data_ok) FrameData <= s_data[FrameBitsPerRow-1:0];
      if (state == STROBE && cnt == StrobeLast) frames_done <= frames_done + 16'd1;
    end
  end

`ifdef CONFIG_CHECKSUM_EN
  logic [31:0] checksum;

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn)                           checksum <= '0;
    else if (state == IDLE && xfer && is_clear) checksum <= '0;
    else if (data_ok)                      checksum <= checksum ^ s_data;
  end

  assign cfg_checksum = checksum;
`else
  assign cfg_checksum = 32'h0;
`endif

endmodule
